matrix_ascii_parser: RTL and testbench
======================================

MATRIX_ASCII_PARSER -- requirements
Module: matrix_ascii_parser

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 9: bit width of each parsed element.
REQ-002 The block SHALL have parameter ELEM_COUNT, default 80: number of elements per matrix.
REQ-003 The block SHALL have parameter COLS, default 10: elements per row, used for the wr_row and wr_col indices.
REQ-004 clk  input  1: clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 start  input  1: level; arms a parse when the block is idle.
REQ-007 busy  output  1: high while a parse is in progress.
REQ-008 done  output  1: one-cycle pulse when ELEM_COUNT elements have been written.
REQ-009 err_code  output  2: sticky error status; 00 none, 01 invalid character, 10 value overflow.
REQ-010 rx_valid  input  1: one-cycle strobe marking rx_data as valid.
REQ-011 rx_data  input  8: received byte from the UART receiver.
REQ-012 wr_en  output  1: one-cycle element write strobe.
REQ-013 wr_addr  output  7: linear element index, 0..ELEM_COUNT-1.
REQ-014 wr_row  output  4: wr_addr / COLS.
REQ-015 wr_col  output  4: wr_addr % COLS.
REQ-016 wr_data  output  DATA_WIDTH: parsed unsigned value.

Function
REQ-017 The FSM SHALL have states IDLE, SKIP (between tokens), ACCUM (inside a token), FINISH and HOLD.
REQ-018 In IDLE, start=1 SHALL:
- clear the accumulator, the element counter and err_code;
- set busy=1 on the next edge;
- go to SKIP.
REQ-019 The block SHALL ignore rx_valid in IDLE and HOLD.
REQ-020 A digit is a byte 0x30..0x39; a separator is a byte 0x20, 0x0A, 0x0D or 0x09.
REQ-021 In SKIP, on a digit, the accumulator SHALL load the digit value and the FSM SHALL go to ACCUM; a separator SHALL leave the FSM in SKIP.
REQ-022 In ACCUM, each digit SHALL update the accumulator to acc*10 + digit, using at least DATA_WIDTH+4 bits internally.
REQ-023 Overflow handling SHALL be:
- any result above 2^DATA_WIDTH-1 saturates the accumulator to 2^DATA_WIDTH-1;
- err_code is set to 10 unless it is already 01;
- parsing continues.
REQ-024 Leading zeros SHALL be accepted, e.g. "007" is 7.
REQ-025 In ACCUM, a separator SHALL end the token on the edge that samples it, with these registered outputs on the next cycle:
- wr_en=1;
- wr_data = accumulator;
- wr_addr, wr_row, wr_col = the current element index.
REQ-026 After each token write, the element counter SHALL increment and the FSM SHALL go to SKIP.
REQ-027 wr_col SHALL wrap 9->0 with wr_row incrementing; the block SHALL NOT use a divider for this.
REQ-028 A byte that is neither a digit nor a separator, in SKIP or ACCUM, SHALL:
- set err_code=01;
- suppress any pending write;
- clear busy;
- send the FSM to HOLD.
REQ-029 When the write of element ELEM_COUNT-1 issues, the FSM SHALL go to FINISH; on the following cycle done=1 and busy=0 for exactly one cycle, then the FSM goes to HOLD.
REQ-030 In HOLD, the FSM SHALL return to IDLE only once start=0, so a held start re-arms nothing.
REQ-031 start asserted while busy SHALL be ignored.
REQ-032 Each rx_valid byte SHALL be fully consumed in one cycle; back-to-back rx_valid on consecutive cycles SHALL be supported with no byte loss.
REQ-033 wr_en SHALL never be high for two consecutive cycles.
REQ-034 wr_data, wr_addr, wr_row and wr_col SHALL hold their last values while wr_en=0.

Reset
REQ-035 With rst_n=0, at any time including mid-parse, the block SHALL immediately force:
- FSM to IDLE;
- busy=0, done=0, wr_en=0;
- err_code=00;
- wr_addr=0, wr_row=0, wr_col=0, wr_data=0;
- accumulator=0, element counter=0.
REQ-036 No write or done pulse SHALL occur for bytes received during reset or in the first cycle after reset release.

Verification
REQ-037 Full matrix:
- Stimulus: pulse start, then send 80 tokens "0".."79" separated by ' ', with LF after every 10th token.
- Response: 80 wr_en pulses with wr_data = wr_addr; wr_row/wr_col run (0,0)..(7,9); done pulses once after the last write; err_code=00.
REQ-038 Formatting edge cases:
- Stimulus: "  255\r\n  7 " as the first tokens, with leading and repeated separators.
- Response: writes at wr_addr 0 (data 255) and wr_addr 1 (data 7) only; no empty-token writes.
REQ-039 Overflow:
- Stimulus: token "1234 ".
- Response: wr_data=511, err_code=10, parse continues.
REQ-040 Invalid character:
- Stimulus: "12x".
- Response: no write, err_code=01, busy falls the cycle after 'x', no done; with start held high the block stays in HOLD, and it rearms after start goes 0 then 1.
REQ-041 Reset mid-parse:
- Stimulus: rst_n low after 5 tokens.
- Response: all outputs reach reset values asynchronously; after release a new start restarts at wr_addr=0.
REQ-042 Back-to-back bytes:
- Stimulus: rx_valid high on every cycle for "9 8 ".
- Response: wr_en high exactly twice, non-consecutive, with data 9 then 8.

Source files
------------

// File: rtl/matrix_ascii_parser_if.sv
// Bundle for the ASCII matrix parser: control/status, UART byte strobe and element write port.
// The slave modport is the parser side; the master modport is the driver/observer side.
interface matrix_ascii_parser_if #(
    parameter int DATA_WIDTH = 9
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [1:0]            err_code;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  wr_en;
    logic [6:0]            wr_addr;
    logic [3:0]            wr_row;
    logic [3:0]            wr_col;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output start, rx_valid, rx_data,
        input  busy, done, err_code, wr_en, wr_addr, wr_row, wr_col, wr_data
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output busy, done, err_code, wr_en, wr_addr, wr_row, wr_col, wr_data
    );
endinterface

// File: rtl/matrix_ascii_parser.sv
// Parses whitespace-separated unsigned decimal tokens from a UART byte stream into a matrix,
// issuing one element write per token with linear, row and column indices.
module matrix_ascii_parser #(
    parameter int DATA_WIDTH = 9,
    parameter int ELEM_COUNT = 80,
    parameter int COLS       = 10
) (
    input logic                   clk,
    input logic                   rst_n,
    matrix_ascii_parser_if.slave  bus
);
    localparam int AW = DATA_WIDTH + 4;
    localparam logic [DATA_WIDTH-1:0] MaxVal = '1;

    typedef enum logic [2:0] {StIdle, StSkip, StAccum, StFinish, StHold} state_e;

    state_e                r_state, w_state_d;
    logic [DATA_WIDTH-1:0] r_acc, w_acc_d;
    logic [6:0]            r_cnt, w_cnt_d;
    logic [3:0]            r_row, w_row_d;
    logic [3:0]            r_col, w_col_d;
    logic [1:0]            r_err, w_err_d;
    logic                  r_busy, w_busy_d;
    logic                  r_done, w_done_d;
    logic                  r_wr_en, w_wr_en_d;
    logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_d;
    logic [6:0]            r_wr_addr, w_wr_addr_d;
    logic [3:0]            r_wr_row, w_wr_row_d;
    logic [3:0]            r_wr_col, w_wr_col_d;

    logic          w_digit;
    logic          w_sep;
    logic [AW-1:0] w_mac;

    assign w_digit = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign w_sep   = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h0A) ||
                     (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h09);
    // Four spare bits hold acc*10+9 for any acc below 2^DATA_WIDTH.
    assign w_mac   = AW'(r_acc) * AW'(10) + AW'(bus.rx_data[3:0]);

    always_comb begin
        w_state_d   = r_state;
        w_acc_d     = r_acc;
        w_cnt_d     = r_cnt;
        w_row_d     = r_row;
        w_col_d     = r_col;
        w_err_d     = r_err;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_wr_en_d   = 1'b0;
        w_wr_data_d = r_wr_data;
        w_wr_addr_d = r_wr_addr;
        w_wr_row_d  = r_wr_row;
        w_wr_col_d  = r_wr_col;

        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_acc_d   = '0;
                    w_cnt_d   = '0;
                    w_row_d   = '0;
                    w_col_d   = '0;
                    w_err_d   = 2'b00;
                    w_busy_d  = 1'b1;
                    w_state_d = StSkip;
                end
            end
            StSkip: begin
                if (bus.rx_valid) begin
                    if (w_digit) begin
                        w_acc_d   = DATA_WIDTH'(bus.rx_data[3:0]);
                        w_state_d = StAccum;
                    end else if (!w_sep) begin
                        w_err_d   = 2'b01;
                        w_busy_d  = 1'b0;
                        w_state_d = StHold;
                    end
                end
            end
            StAccum: begin
                if (bus.rx_valid) begin
                    if (w_digit) begin
                        if (w_mac > AW'(MaxVal)) begin
                            w_acc_d = MaxVal;
                            if (r_err != 2'b01) w_err_d = 2'b10;
                        end else begin
                            w_acc_d = w_mac[DATA_WIDTH-1:0];
                        end
                    end else if (w_sep) begin
                        w_wr_en_d   = 1'b1;
                        w_wr_data_d = r_acc;
                        w_wr_addr_d = r_cnt;
                        w_wr_row_d  = r_row;
                        w_wr_col_d  = r_col;
                        w_cnt_d     = r_cnt + 7'd1;
                        // Row/column tracked incrementally so no divider is needed.
                        if (r_col == 4'(COLS - 1)) begin
                            w_col_d = '0;
                            w_row_d = r_row + 4'd1;
                        end else begin
                            w_col_d = r_col + 4'd1;
                        end
                        w_state_d = (r_cnt == 7'(ELEM_COUNT - 1)) ? StFinish : StSkip;
                    end else begin
                        w_err_d   = 2'b01;
                        w_busy_d  = 1'b0;
                        w_state_d = StHold;
                    end
                end
            end
            StFinish: begin
                w_done_d  = 1'b1;
                w_busy_d  = 1'b0;
                w_state_d = StHold;
            end
            StHold: begin
                if (!bus.start) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_err     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
        end else begin
            r_state   <= w_state_d;
            r_acc     <= w_acc_d;
            r_cnt     <= w_cnt_d;
            r_row     <= w_row_d;
            r_col     <= w_col_d;
            r_err     <= w_err_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_wr_en   <= w_wr_en_d;
            r_wr_data <= w_wr_data_d;
            r_wr_addr <= w_wr_addr_d;
            r_wr_row  <= w_wr_row_d;
            r_wr_col  <= w_wr_col_d;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err_code = r_err;
    assign bus.wr_en    = r_wr_en;
    assign bus.wr_data  = r_wr_data;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_row   = r_wr_row;
    assign bus.wr_col   = r_wr_col;
endmodule

// File: tb/tb_matrix_ascii_parser.sv
// Scoreboard bench for matrix_ascii_parser: expected writes are queued as bytes are issued and a
// monitor pops and compares them whenever wr_en is seen.
module tb_matrix_ascii_parser;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    matrix_ascii_parser_if #(.DATA_WIDTH(9)) bus ();

    matrix_ascii_parser #(
        .DATA_WIDTH(9),
        .ELEM_COUNT(80),
        .COLS      (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic [6:0] addr;
        logic [3:0] row;
        logic [3:0] col;
        logic [8:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_pass   = 0;
    int  n_total  = 0;
    int  wr_cnt   = 0;
    int  done_cnt = 0;
    logic prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_w(input int addr, input int data);
        wr_t e;
        e.addr = 7'(addr);
        e.row  = 4'(addr / 10);
        e.col  = 4'(addr % 10);
        e.data = 9'(data);
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered on posedge, sampled here on negedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                wr_t act;
                wr_t exp;
                wr_cnt++;
                act = {bus.wr_addr, bus.wr_row, bus.wr_col, bus.wr_data};
                check("wr_en_gap", 32'(prev_wr), 32'd0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%0d, expected no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    exp = exp_q.pop_front();
                    check("wr_addr_row_col_data", 32'(act), 32'(exp));
                end
            end
            if (bus.done) done_cnt++;
        end
        prev_wr = bus.wr_en;
    end

    task automatic send_str(input string s, input bit b2b);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = s[i];
            if (!b2b) begin
                @(negedge clk);
                bus.rx_valid = 1'b0;
            end
        end
        if (b2b) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int d0;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_err", 32'(bus.err_code), 32'd0);
        check("rst_wr_fields", 32'({bus.wr_addr, bus.wr_row, bus.wr_col, bus.wr_data}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Full 8x10 matrix: tokens 0..79, LF after every 10th
        pulse_start();
        check("start_busy", 32'(bus.busy), 32'd1);
        w0 = wr_cnt;
        for (int i = 0; i < 80; i++) begin
            push_w(i, i);
            send_str($sformatf("%0d%s", i, (i % 10 == 9) ? "\n" : " "), 1'b0);
        end
        for (int i = 0; i < 10 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("full_done_count", 32'(done_cnt), 32'd1);
        check("full_wr_count", 32'(wr_cnt - w0), 32'd80);
        check("full_err", 32'(bus.err_code), 32'd0);
        check("full_busy_after", 32'(bus.busy), 32'd0);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // Leading/repeated separators, then reset mid-parse after 5 tokens
        pulse_start();
        w0 = wr_cnt;
        push_w(0, 255);
        push_w(1, 7);
        send_str("  255\015\n  7 ", 1'b0);
        wait_drain("fmt_drain");
        check("fmt_wr_count", 32'(wr_cnt - w0), 32'd2);
        push_w(2, 1);
        push_w(3, 2);
        push_w(4, 3);
        send_str("1 2 3 ", 1'b0);
        wait_drain("pre_rst_drain");
        check("pre_rst_addr", 32'(bus.wr_addr), 32'd4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_wr_fields",
              32'({bus.wr_addr, bus.wr_row, bus.wr_col, bus.wr_data}), 32'd0);
        check("async_rst_err", 32'(bus.err_code), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Overflow saturates, parse continues; then invalid character in the same parse
        d0 = done_cnt;
        pulse_start();
        push_w(0, 511);
        send_str("1234 ", 1'b0);
        wait_drain("ovf_drain");
        check("ovf_err", 32'(bus.err_code), 32'd2);
        check("ovf_busy", 32'(bus.busy), 32'd1);
        push_w(1, 5);
        send_str("5 ", 1'b0);
        wait_drain("ovf_continue_drain");
        w0 = wr_cnt;
        send_str("12", 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = "x";
        check("inv_busy_before", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("inv_busy_after", 32'(bus.busy), 32'd0);
        check("inv_err", 32'(bus.err_code), 32'd1);
        bus.start = 1'b1;
        repeat (5) @(negedge clk);
        check("inv_no_write", 32'(wr_cnt - w0), 32'd0);
        check("inv_no_done", 32'(done_cnt - d0), 32'd0);
        check("hold_busy", 32'(bus.busy), 32'd0);
        check("hold_err", 32'(bus.err_code), 32'd1);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        pulse_start();
        check("rearm_busy", 32'(bus.busy), 32'd1);
        check("rearm_err", 32'(bus.err_code), 32'd0);

        // Back-to-back bytes
        w0 = wr_cnt;
        push_w(0, 9);
        push_w(1, 8);
        send_str("9 8 ", 1'b1);
        wait_drain("b2b_drain");
        check("b2b_wr_count", 32'(wr_cnt - w0), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
